// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for the RV32 single-cycle core. It issues word-aligned requests
// to instruction memory and accepts the in-order responses. Each response is
// buffered together with its PC in a small FIFO, and the FIFO head is presented
// to the core. A redirect (taken jump or branch) flushes the buffer. Responses
// that are still in flight at the redirect are dropped when they come back.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   imem_req_valid_o      request valid toward instruction memory
//   imem_req_ready_i      memory accepts the request this cycle
//   imem_req_addr_o       word-aligned fetch address
//   imem_rsp_valid_i      response valid (always accepted)
//   imem_rsp_data_i       instruction word
//   imem_rsp_err_i        access fault for this response
//   redirect_i            flush and restart fetch at redirect_pc_i
//   redirect_pc_i         new PC; bits [1:0] are ignored
//   instr_valid_o         FIFO head valid
//   instr_ready_i         core consumes the head
//   instr_o, instr_pc_o   head instruction and its PC
//   instr_err_o           head carries an access fault
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_err_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
  } entry_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

  // Architectural state
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
  cnt_t            outst_q,    outst_d;
  cnt_t            drop_q,     drop_d;
  cnt_t            fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  entry_t          fifo_mem [FIFO_DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_pc_aligned;
  entry_t          head;

  // The low PC bits of a redirect target are forced to zero, so they are not read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Credit scheme: a new request is allowed only while the in-flight requests
  // plus the buffered entries leave room in the FIFO. Every response therefore
  // has a free slot waiting for it.
  assign credit_used      = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign imem_req_valid_o = !rst_i && !redirect_i && (credit_used < DEPTH_W);
  assign imem_req_addr_o  = fetch_pc_q;

  assign issue = imem_req_valid_o && imem_req_ready_i;
  // A response is stored only when it is not stale (drop_q == 0) and no redirect
  // is flushing the stream in this same cycle.
  assign push  = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
  assign pop   = instr_valid_o && instr_ready_i && !redirect_i;

  assign instr_valid_o = (fifo_cnt_q != '0);
  assign head          = fifo_mem[rd_ptr_q];
  // Outputs read zero while the buffer is empty, so the unreset storage never shows through.
  assign instr_o       = instr_valid_o ? head.data : '0;
  assign instr_pc_o    = instr_valid_o ? head.pc   : '0;
  assign instr_err_o   = instr_valid_o ? head.err  : 1'b0;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first. Any path that skips an assignment would otherwise infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + cnt_t'(issue) - cnt_t'(imem_rsp_valid_i);
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + PC_STEP;
    end
    if (imem_rsp_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - cnt_t'(1);
    end

    if (redirect_i) begin
      // Every request still in flight after this cycle belongs to the old
      // stream. That includes none issued this cycle, because the request is
      // gated off. A response arriving right now is already discarded because
      // it is not pushed.
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      drop_d     = outst_q - cnt_t'(imem_rsp_valid_i);
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking '<=' so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: the entry storage is deliberately left without reset. Validity comes
  // only from fifo_cnt_q, so resetting the data would cost flops and gain nothing.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_mem[wr_ptr_q] <= '{err: imem_rsp_err_i, pc: rsp_pc_q, data: imem_rsp_data_i};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. The bench contains an in-order
// instruction memory with a configurable fixed latency. Each word's content is
// a function of its address. A stream-level model tracks the following:
//   - the requests in flight, each tagged with the fetch epoch it belongs to;
//   - the PCs the core should see next.
// Redirects and resets open a new epoch. Responses from an older epoch must
// never reach the core.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_err_o;

  instr_fetch_unit #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_err_o      (instr_err_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- model --
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       memq[$];      // accepted requests still owed a response
  logic [31:0] fifo_pc[$];   // PCs the core is still owed, in order
  int          epoch;
  int          cyc;
  int          last_due;
  int          mem_lat;
  logic [31:0] fetch_pc;
  logic [31:0] err_addr;
  bit          model_ok;

  int          checks;
  int          errors;
  int          n_req;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  function automatic bit exp_req_valid();
    return !rst_i && !redirect_i && (memq.size() + fifo_pc.size() < DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply the clock edge that has just occurred to the model, using the inputs
  // that were held across that edge.
  task automatic advance_model();
    bit          issue;
    bit          pop;
    mreq_t       r;
    logic [31:0] dummy;
    issue = model_ok && exp_req_valid() && (imem_req_ready_i === 1'b1);
    if (rst_i) begin
      memq.delete();
      fifo_pc.delete();
      fetch_pc = RESET_PC;
      epoch++;
      last_due = cyc;
      model_ok = 1'b1;
    end else if (model_ok) begin
      pop = (fifo_pc.size() > 0) && instr_ready_i && !redirect_i;
      if (imem_rsp_valid_i) r = memq.pop_front();
      if (redirect_i) begin
        fifo_pc.delete();
        fetch_pc = {redirect_pc_i[31:2], 2'b00};
        epoch++;
      end else begin
        if (pop) dummy = fifo_pc.pop_front();
        if (imem_rsp_valid_i && r.epoch == epoch) fifo_pc.push_back(r.addr);
      end
      if (issue) begin
        r.addr  = fetch_pc;
        r.epoch = epoch;
        r.due   = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due + 1;
        last_due = r.due;
        memq.push_back(r);
        fetch_pc = fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic compare();
    if (!model_ok) return;
    check("req_valid", 32'(imem_req_valid_o), 32'(exp_req_valid()));
    if (exp_req_valid()) check("req_addr", imem_req_addr_o, fetch_pc);
    check("instr_valid", 32'(instr_valid_o), 32'(fifo_pc.size() > 0));
    if (fifo_pc.size() > 0) begin
      check("instr_pc",  instr_pc_o, fifo_pc[0]);
      check("instr",     instr_o, word_at(fifo_pc[0]));
      check("instr_err", 32'(instr_err_o), 32'(fifo_pc[0] == err_addr));
    end else begin
      check("idle_instr", instr_o, 32'h0);
      check("idle_pc",    instr_pc_o, 32'h0);
      check("idle_err",   32'(instr_err_o), 32'h0);
    end
    if (imem_req_valid_o === 1'b1 && imem_req_ready_i === 1'b1) begin
      n_req++;
      last_req_addr = imem_req_addr_o;
    end
  endtask

  // Perform one clock cycle: apply the edge to the model, drive the new inputs,
  // let the combinational outputs settle, then compare.
  task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                       input bit rr, input bit ir);
    @(negedge clk_i);
    advance_model();
    rst_i            = rst;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = rr;
    instr_ready_i    = ir;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = word_at(memq[0].addr);
      imem_rsp_err_i   = (memq[0].addr == err_addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'hBAD0_BAD0;
      imem_rsp_err_i   = 1'b1;
    end
    #1;
    compare();
  endtask

  task automatic run(input int n, input bit rr, input bit ir);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rr, ir);
  endtask

  task automatic do_reset(input int lat, input logic [31:0] eaddr);
    mem_lat  = lat;
    err_addr = eaddr;
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    n_req = 0;
  endtask

  task automatic run_until_pc(input string name, input logic [31:0] pc, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (instr_valid_o === 1'b1 && instr_pc_o === pc) seen = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    check(name, 32'(seen), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit [31:0] rr_pat;
    bit [31:0] ir_pat;
    checks   = 0;
    errors   = 0;
    epoch    = 0;
    cyc      = 0;
    last_due = 0;
    n_req    = 0;
    mem_lat  = 1;
    err_addr = 32'hFFFF_FFFF;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_req_ready_i = 1'b1; instr_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; imem_rsp_err_i = 1'b0;

    // 1: streaming from reset with 1-cycle memory
    do_reset(1, 32'hFFFF_FFFF);
    check("t1_rst_req_valid",   32'(imem_req_valid_o), 32'h0);
    check("t1_rst_instr_valid", 32'(instr_valid_o), 32'h0);
    check("t1_rst_instr",       instr_o, 32'h0);
    run(1, 1'b1, 1'b1);
    check("t1_req0_valid", 32'(imem_req_valid_o), 32'h1);
    check("t1_req0_addr",  imem_req_addr_o, 32'h0);
    run(1, 1'b1, 1'b1);
    check("t1_req1_addr",  imem_req_addr_o, 32'h4);
    check("t1_not_yet",    32'(instr_valid_o), 32'h0);
    run(1, 1'b1, 1'b1);
    check("t1_first_valid", 32'(instr_valid_o), 32'h1);
    check("t1_first_pc",    instr_pc_o, 32'h0);
    check("t1_first_instr", instr_o, 32'hDEAD_0013);
    run(1, 1'b1, 1'b1);
    check("t1_second_pc",   instr_pc_o, 32'h4);
    check("t1_second_instr", instr_o, 32'hDEAD_0017);
    run(6, 1'b1, 1'b1);

    // 2: core stalled, credits run out at FIFO_DEPTH
    do_reset(1, 32'hFFFF_FFFF);
    run(8, 1'b1, 1'b0);
    check("t2_req_count",  32'(n_req), 32'd4);
    check("t2_last_addr",  last_req_addr, 32'hC);
    check("t2_req_stopped", 32'(imem_req_valid_o), 32'h0);
    check("t2_head_pc",    instr_pc_o, 32'h0);
    run(1, 1'b1, 1'b1);
    run(1, 1'b1, 1'b1);
    check("t2_resume_valid", 32'(imem_req_valid_o), 32'h1);
    check("t2_resume_addr",  imem_req_addr_o, 32'h10);
    check("t2_head_after_pop", instr_pc_o, 32'h4);
    run(8, 1'b1, 1'b1);

    // 3: redirect with two requests in flight on a 3-cycle memory
    do_reset(3, 32'hFFFF_FFFF);
    run(2, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    check("t3_no_req_on_redirect", 32'(imem_req_valid_o), 32'h0);
    run_until_pc("t3_first_after_redirect", 32'h100, 12);
    check("t3_data_0x100", instr_o, 32'hDEAD_0113);
    run(6, 1'b1, 1'b1);

    // 4: redirect coinciding with a response and a pop
    do_reset(1, 32'hFFFF_FFFF);
    run(4, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h202, 1'b1, 1'b1);
    check("t4_nonempty_at_redirect", 32'(instr_valid_o), 32'h1);
    run(1, 1'b1, 1'b1);
    check("t4_flushed",     32'(instr_valid_o), 32'h0);
    check("t4_new_addr",    imem_req_addr_o, 32'h200);
    run_until_pc("t4_first_pc", 32'h200, 5);
    check("t4_first_instr", instr_o, 32'hDEAD_0213);
    run(4, 1'b1, 1'b1);

    // 5: access fault on 0x8 travels with its entry only
    do_reset(1, 32'h8);
    run_until_pc("t5_reach_0x8", 32'h8, 10);
    check("t5_err_set",  32'(instr_err_o), 32'h1);
    check("t5_err_data", instr_o, 32'hDEAD_001B);
    run(1, 1'b1, 1'b1);
    check("t5_next_pc",  instr_pc_o, 32'hC);
    check("t5_err_clear", 32'(instr_err_o), 32'h0);
    run(3, 1'b1, 1'b1);

    // 6: reset with requests in flight and a non-empty buffer
    do_reset(3, 32'hFFFF_FFFF);
    run(5, 1'b1, 1'b0);
    check("t6_busy_before", 32'(instr_valid_o), 32'h1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    check("t6_req_off_in_reset", 32'(imem_req_valid_o), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("t6_valid_cleared", 32'(instr_valid_o), 32'h0);
    check("t6_instr_cleared", instr_o, 32'h0);
    check("t6_restart_addr",  imem_req_addr_o, RESET_PC);
    run_until_pc("t6_first_pc", 32'h0, 8);
    check("t6_first_instr", instr_o, 32'hDEAD_0013);
    run(4, 1'b1, 1'b1);

    // 7: back-to-back redirects, address wrap, irregular ready patterns
    mem_lat = 2;
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1);
    run_until_pc("t7_wrap_top", 32'hFFFF_FFFC, 10);
    check("t7_wrap_top_instr", instr_o, 32'h2152_FFEF);
    run_until_pc("t7_wrap_zero", 32'h0, 3);
    rr_pat = 32'b1011_0111_0010_1111_1100_1010_0111_1101;
    ir_pat = 32'b0110_1101_1110_0011_0101_1111_1001_0110;
    for (int i = 0; i < 32; i++) begin
      if (i == 17) cycle(1'b0, 1'b1, 32'h500, rr_pat[i], ir_pat[i]);
      else         cycle(1'b0, 1'b0, 32'h0,   rr_pat[i], ir_pat[i]);
    end
    run(12, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
